fpm_exp: RTL and testbench
==========================

// Module: fpm_exp
// PURPOSE
//  Parametrised exponent/alignment sequencer for the FPU microoperation path. It computes the
//  exponent result and drives the mantissa shifter step by step:
//   - operand alignment for AF/SF
//   - exponent sum for MF and exponent difference for DF
//   - post-normalisation with a zero-mantissa detect
//  It replaces the fixed 8-bit D/B exponent path and its shift counter with a width-generic FSM.
//  Over/underflow flags drive the interrupt logic.
// PARAMETERS
//  EW  8   exponent width, two's complement signed
//  MW  40  mantissa width; alignment saturates at MW, normalise gives up after MW steps
//  CW  6   shift-counter width, must hold MW
// PORTS
//  __clk     in   1   system clock, all state on rising edge
//  _0_f_     in   1   async active-low reset (asynchronous, active-low)
//  start     in   1   begin operation, sampled only in IDLE
//  abort     in   1   sync cancel, back to IDLE, no done
//  op        in   2   00 align(AF/SF), 01 mul exp sum, 10 div exp diff, 11 normalise
//  ea        in   EW  exponent A, captured at start
//  eb        in   EW  exponent B, captured at start
//  sh_rdy    in   1   mantissa shifter accepted current shr/shl step
//  norm_ok   in   1   mantissa normalised (T0 != T1) from mantissa unit
//  busy      out  1   FSM not in IDLE
//  done      out  1   1-cycle pulse in FIN
//  shr       out  1   request right shift (align)
//  shl       out  1   request left shift (normalise)
//  shamt     out  CW  shift amount qualifying shr/shl
//  swap      out  1   eb > ea, mantissa unit aligns operand A instead of B
//  g         out  1   |ea-eb| >= MW (smaller operand fully shifted out)
//  e_out     out  EW  result exponent, low EW bits of internal value
//  of        out  1   result exponent > 2^(EW-1)-1
//  uf        out  1   result exponent < -2^(EW-1)
//  zero      out  1   normalise found zero mantissa
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal e_r, cnt, captured operands cleared.
//  Internal e_r is EW+2 bit signed, so sums and differences never wrap internally.
//  States: IDLE -> CALC -> {ALIGN | NORM | FIN} -> FIN -> IDLE.
//  IDLE: start=1 -> capture ea/eb/op, go CALC. start while busy is ignored.
//   - ALIGN op: d=ea-eb; swap=(d<0); g=(|d|>=MW); cnt=min(|d|,MW); e_r=max(ea,eb).
//     cnt==0 -> FIN, else -> ALIGN.
//   - MUL op: e_r=ea+eb; -> FIN.
//   - DIV op: e_r=ea-eb; -> FIN.
//   - NORM op: e_r=ea; cnt=0; -> NORM.
//  ALIGN: shr=1, shamt=1; each cycle with sh_rdy=1: cnt-=1; step where cnt reaches 0 -> FIN.
//   sh_rdy=0 holds state and request; shr stays asserted until accepted.
//  NORM, checked in this priority order:
//   - norm_ok=1 -> FIN, no shift.
//   - cnt==MW -> zero=1, e_r=0 -> FIN.
//   - else shl=1, shamt=1; on sh_rdy: e_r-=1, cnt+=1.
//  FIN: done=1 for 1 cycle, then IDLE.
//   - e_out, of, uf, zero, swap and g are set in FIN and held until the next start leaves IDLE.
//   - of/uf are evaluated on e_r; zero forces of=uf=0.
//  Latency with sh_rdy tied 1: MUL/DIV start->done 2 cycles. ALIGN 2+cnt, NORM 2+steps.
//  abort=1 in any non-IDLE state -> IDLE next edge; flags keep previous values; done not pulsed.
//  abort has priority over sh_rdy in the same cycle; the step is not counted.
//  Reset asserted mid-operation clears everything immediately, no done.
// CONFIGURATION
//  FPM_EXP_FASTALIGN_EN defined:
//   - ALIGN issues one shr with shamt=cnt (barrel shifter).
//   - A single sh_rdy completes it and goes to FIN; ALIGN latency becomes 3 cycles.
//  FPM_EXP_FASTALIGN_EN undefined:
//   - One-bit steps as above.
//   - shamt is 1 whenever shr/shl=1, else 0.
//  NORM is always one-bit steps.
// TESTING
//  1 ALIGN ea=5, eb=2, sh_rdy=1 -> 3 shr pulses, swap=0, g=0, e_out=5; done 5 cycles after start.
//  2 ALIGN ea=-10, eb=50 -> swap=1, g=1, 40 shr steps (1 if FASTALIGN, shamt=40), e_out=50.
//  3 MUL ea=100, eb=60 -> e_out=8'hA0, of=1, uf=0, done 2 cycles after start.
//  4 NORM ea=-126, norm_ok after 3 accepted shl -> e_out=8'h7F (-129 truncated), uf=1.
//  5 NORM with norm_ok=0 always -> 40 shl, zero=1, e_out=0, of=uf=0.
//  6 ALIGN with sh_rdy toggled 1/0, abort mid-ALIGN, and reset mid-NORM -> no step lost or doubled;
//    abort: IDLE, no done; reset: all outputs 0.

Source files
------------

// File: rtl/fpm_exp.sv
// fpm_exp: width-generic exponent/alignment sequencer driving the FPU mantissa shifter.
// Optional macro FPM_EXP_FASTALIGN_EN: alignment is one barrel shift of shamt=cnt.
module fpm_exp #(
  parameter int EW = 8,
  parameter int MW = 40,
  parameter int CW = 6
) (
  input  logic          __clk,
  input  logic          _0_f_,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    op,
  input  logic [EW-1:0] ea,
  input  logic [EW-1:0] eb,
  input  logic          sh_rdy,
  input  logic          norm_ok,
  output logic          busy,
  output logic          done,
  output logic          shr,
  output logic          shl,
  output logic [CW-1:0] shamt,
  output logic          swap,
  output logic          g,
  output logic [EW-1:0] e_out,
  output logic          of,
  output logic          uf,
  output logic          zero
);

  localparam int XW = EW + 2;
  localparam logic signed [XW-1:0] MW_X  = XW'(MW);
  localparam logic signed [XW-1:0] E_MAX = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] E_MIN = XW'(-(1 << (EW - 1)));
  localparam logic signed [XW-1:0] ONE_X = XW'(1);
  localparam logic [CW-1:0]        MW_C  = CW'(MW);
  localparam logic [CW-1:0]        ONE_C = CW'(1);
  localparam logic [CW-1:0]        ZERO_C = CW'(0);

  localparam logic [1:0] OP_ALIGN = 2'b00;
  localparam logic [1:0] OP_MUL   = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_NORM  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_ALIGN = 3'd2,
    S_NORM  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t               state_r, state_nx_s;
  logic [1:0]           op_r;
  logic [EW-1:0]        ea_r, eb_r;
  logic signed [XW-1:0] e_r, e_nx_s;
  logic [CW-1:0]        cnt_r, cnt_nx_s;
  logic                 sw_r, sw_nx_s, g_r, g_nx_s, zero_nx_s;
  logic signed [XW-1:0] ea_x_s, eb_x_s, d_s, ad_s;
  logic                 fin_entry_s;

  // Two extra sign bits keep sums, differences and normalise decrements from wrapping.
  assign ea_x_s = {{2{ea_r[EW-1]}}, ea_r};
  assign eb_x_s = {{2{eb_r[EW-1]}}, eb_r};
  assign d_s    = ea_x_s - eb_x_s;
  assign ad_s   = d_s[XW-1] ? -d_s : d_s;

  // Next-state, working exponent and shift counter.
  always_comb begin
    state_nx_s = state_r;
    e_nx_s     = e_r;
    cnt_nx_s   = cnt_r;
    sw_nx_s    = sw_r;
    g_nx_s     = g_r;
    zero_nx_s  = 1'b0;
    if (abort && (state_r != S_IDLE)) begin
      state_nx_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_nx_s = S_CALC;
          end else begin
            state_nx_s = S_IDLE;
          end
        end
        S_CALC: begin
          sw_nx_s = 1'b0;
          g_nx_s  = 1'b0;
          case (op_r)
            OP_ALIGN: begin
              sw_nx_s  = d_s[XW-1];
              g_nx_s   = (ad_s >= MW_X);
              cnt_nx_s = g_nx_s ? MW_C : ad_s[CW-1:0];
              e_nx_s   = d_s[XW-1] ? eb_x_s : ea_x_s;
              if (cnt_nx_s == ZERO_C) begin
                state_nx_s = S_FIN;
              end else begin
                state_nx_s = S_ALIGN;
              end
            end
            OP_MUL: begin
              e_nx_s     = ea_x_s + eb_x_s;
              state_nx_s = S_FIN;
            end
            OP_DIV: begin
              e_nx_s     = d_s;
              state_nx_s = S_FIN;
            end
            OP_NORM: begin
              e_nx_s     = ea_x_s;
              cnt_nx_s   = ZERO_C;
              state_nx_s = S_NORM;
            end
            default: state_nx_s = S_FIN;
          endcase
        end
        S_ALIGN: begin
`ifdef FPM_EXP_FASTALIGN_EN
          if (sh_rdy) begin
            cnt_nx_s   = ZERO_C;
            state_nx_s = S_FIN;
          end else begin
            state_nx_s = S_ALIGN;
          end
`else
          if (sh_rdy) begin
            cnt_nx_s = cnt_r - ONE_C;
            if (cnt_r == ONE_C) begin
              state_nx_s = S_FIN;
            end else begin
              state_nx_s = S_ALIGN;
            end
          end else begin
            state_nx_s = S_ALIGN;
          end
`endif
        end
        S_NORM: begin
          if (norm_ok) begin
            state_nx_s = S_FIN;
          end else if (cnt_r == MW_C) begin
            zero_nx_s  = 1'b1;
            e_nx_s     = '0;
            state_nx_s = S_FIN;
          end else if (sh_rdy) begin
            e_nx_s   = e_r - ONE_X;
            cnt_nx_s = cnt_r + ONE_C;
          end else begin
            state_nx_s = S_NORM;
          end
        end
        S_FIN:   state_nx_s = S_IDLE;
        default: state_nx_s = S_IDLE;
      endcase
    end
  end

  assign fin_entry_s = (state_nx_s == S_FIN) && (state_r != S_FIN);

  // FSM state, captured operands and working registers.
  always_ff @(posedge __clk or negedge _0_f_) begin
    if (!_0_f_) begin
      state_r <= S_IDLE;
      op_r    <= 2'b00;
      ea_r    <= '0;
      eb_r    <= '0;
      e_r     <= '0;
      cnt_r   <= '0;
      sw_r    <= 1'b0;
      g_r     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      e_r     <= e_nx_s;
      cnt_r   <= cnt_nx_s;
      sw_r    <= sw_nx_s;
      g_r     <= g_nx_s;
      if ((state_r == S_IDLE) && start) begin
        op_r <= op;
        ea_r <= ea;
        eb_r <= eb;
      end
    end
  end

  // Result flags are loaded on entry to FIN so they are valid alongside done.
  always_ff @(posedge __clk or negedge _0_f_) begin
    if (!_0_f_) begin
      e_out <= '0;
      of    <= 1'b0;
      uf    <= 1'b0;
      zero  <= 1'b0;
      swap  <= 1'b0;
      g     <= 1'b0;
    end else if (fin_entry_s) begin
      e_out <= e_nx_s[EW-1:0];
      of    <= !zero_nx_s && (e_nx_s > E_MAX);
      uf    <= !zero_nx_s && (e_nx_s < E_MIN);
      zero  <= zero_nx_s;
      swap  <= sw_nx_s;
      g     <= g_nx_s;
    end
  end

  assign busy = (state_r != S_IDLE);
  assign done = (state_r == S_FIN);
  assign shr  = (state_r == S_ALIGN);
  assign shl  = (state_r == S_NORM) && !norm_ok && (cnt_r != MW_C);
`ifdef FPM_EXP_FASTALIGN_EN
  assign shamt = shr ? cnt_r : (shl ? ONE_C : ZERO_C);
`else
  assign shamt = (shr || shl) ? ONE_C : ZERO_C;
`endif

endmodule

// File: tb/tb_fpm_exp.sv
// Self-checking bench for fpm_exp: directed corner cases plus randomized ops vs. an arithmetic model.
`timescale 1ns/1ps
module tb_fpm_exp;
  localparam int EW = 8;
  localparam int MW = 40;
  localparam int CW = 6;
`ifdef FPM_EXP_FASTALIGN_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, sh_rdy = 1'b0, norm_ok = 1'b0;
  logic [1:0] op = 2'b00;
  logic [EW-1:0] ea = '0, eb = '0;
  logic busy, done, shr, shl, swap, g, of, uf, zero;
  logic [CW-1:0] shamt;
  logic [EW-1:0] e_out;

  int n_chk = 0;
  int n_err = 0;
  logic [EW-1:0] last_eo = '0;

  always #5 clk = ~clk;

  fpm_exp #(.EW(EW), .MW(MW), .CW(CW)) dut (
    .__clk(clk), ._0_f_(rst_n), .start(start), .abort(abort), .op(op), .ea(ea), .eb(eb),
    .sh_rdy(sh_rdy), .norm_ok(norm_ok), .busy(busy), .done(done), .shr(shr), .shl(shl),
    .shamt(shamt), .swap(swap), .g(g), .e_out(e_out), .of(of), .uf(uf), .zero(zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    int e;
    bit sw;
    bit gg;
    bit zr;
    int shifts;
  } exp_t;

  // k = number of accepted left shifts before norm_ok rises (k > MW: never).
  function automatic exp_t model(int opc, int a, int b, int k);
    exp_t r;
    int d, ad;
    r = '{default: 0};
    case (opc)
      0: begin
        d = a - b;
        ad = (d < 0) ? -d : d;
        r.sw = (d < 0);
        r.gg = (ad >= MW);
        r.shifts = (ad < MW) ? ad : MW;
        r.e = (a > b) ? a : b;
      end
      1: r.e = a + b;
      2: r.e = a - b;
      default: begin
        if (k <= MW) begin
          r.e = a - k;
          r.shifts = k;
        end else begin
          r.zr = 1'b1;
          r.e = 0;
          r.shifts = MW;
        end
      end
    endcase
    return r;
  endfunction

  // rdy_mode: 0 sh_rdy tied high, 1 random, 2 toggling. exp_lat < 0 skips the latency check.
  task automatic run_op(input string tag, input int opc, input int a, input int b, input int k,
                        input int rdy_mode);
    exp_t m;
    int cyc, nshr, nshl, sum, exp_lat, exp_nshr;
    bit seen;
    logic [EW-1:0] eo;
    int ev;
    m = model(opc, a, b, k);
    ev = m.e;
    eo = ev[EW-1:0];
    exp_lat = -1;
    if (rdy_mode == 0) begin
      if (opc == 1 || opc == 2) exp_lat = 2;
      else if (opc == 0) exp_lat = (m.shifts == 0) ? 2 : (FAST ? 3 : 2 + m.shifts);
      else exp_lat = -1;
    end
    exp_nshr = (opc == 0) ? (FAST ? ((m.shifts > 0) ? 1 : 0) : m.shifts) : 0;
    @(negedge clk);
    start = 1'b1; op = opc[1:0]; ea = a[EW-1:0]; eb = b[EW-1:0]; sh_rdy = 1'b0; norm_ok = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; nshr = 0; nshl = 0; sum = 0; seen = 1'b0;
    while (!seen && cyc < 300) begin
      norm_ok = (nshl == k);
      case (rdy_mode)
        0: sh_rdy = 1'b1;
        1: sh_rdy = 1'($urandom_range(0, 1));
        default: sh_rdy = cyc[0];
      endcase
      #1;
      if (shr && sh_rdy) begin nshr++; sum += int'(shamt); end
      if (shl && sh_rdy) begin nshl++; sum += int'(shamt); end
      if (done) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "/done"}, seen, 1'b1);
    if (exp_lat >= 0) chk({tag, "/latency"}, cyc, exp_lat);
    chk({tag, "/e_out"}, e_out, eo);
    chk({tag, "/of"}, of, !m.zr && (m.e > 127));
    chk({tag, "/uf"}, uf, !m.zr && (m.e < -128));
    chk({tag, "/zero"}, zero, m.zr);
    chk({tag, "/swap"}, swap, m.sw);
    chk({tag, "/g"}, g, m.gg);
    chk({tag, "/shift_sum"}, sum, (opc == 0 || opc == 3) ? m.shifts : 0);
    chk({tag, "/shr_cnt"}, nshr, exp_nshr);
    chk({tag, "/shl_cnt"}, nshl, (opc == 3) ? m.shifts : 0);
    @(negedge clk);
    sh_rdy = 1'b0; norm_ok = 1'b0;
    #1;
    chk({tag, "/idle"}, {busy, done}, 2'b00);
    chk({tag, "/hold"}, e_out, eo);
    last_eo = eo;
  endtask

  initial begin
    int opc, a, b, k;
    logic signed [EW-1:0] ra, rb;
    bit done_seen;
    repeat (3) @(negedge clk);
    #1;
    chk("reset", {busy, done, shr, shl, shamt, swap, g, e_out, of, uf, zero}, '0);
    rst_n = 1'b1;

    run_op("t1_align", 0, 5, 2, 0, 0);
    run_op("t2_align_g", 0, -10, 50, 0, 0);
    run_op("t3_mul", 1, 100, 60, 0, 0);
    run_op("t3_div", 2, -100, 60, 0, 0);
    run_op("t4_norm", 3, -126, 0, 3, 0);
    run_op("t5_normzero", 3, 17, 0, 99, 0);
    run_op("norm_k_mw", 3, 0, 0, MW, 0);
    run_op("align_eq", 0, -7, -7, 0, 0);
    run_op("t6_toggle", 0, 3, 30, 0, 2);

    // Abort mid-ALIGN with sh_rdy high in the same cycle.
    @(negedge clk);
    start = 1'b1; op = 2'b00; ea = 8'd20; eb = 8'd0;
    @(negedge clk);
    start = 1'b0; sh_rdy = 1'b1;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; sh_rdy = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (done || busy) done_seen = 1'b1;
      @(negedge clk);
    end
    chk("abort/idle", done_seen, 1'b0);
    chk("abort/flags_kept", e_out, last_eo);
    run_op("after_abort", 0, 20, 0, 0, 0);

    // Reset mid-NORM clears every output at once.
    @(negedge clk);
    start = 1'b1; op = 2'b11; ea = 8'd10; eb = 8'd0;
    @(negedge clk);
    start = 1'b0; sh_rdy = 1'b1; norm_ok = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_norm", {busy, done, shr, shl, shamt, swap, g, e_out, of, uf, zero}, '0);
    @(negedge clk);
    sh_rdy = 1'b0;
    rst_n = 1'b1;
    last_eo = '0;
    run_op("after_reset", 3, 50, 0, 2, 0);

    for (int n = 0; n < 60; n++) begin
      opc = $urandom_range(0, 3);
      ra = EW'($urandom);
      rb = EW'($urandom);
      a = int'(ra);
      b = int'(rb);
      k = ($urandom_range(0, 3) == 0) ? 99 : $urandom_range(0, MW);
      run_op("rand", opc, a, b, k, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
